// File: rtl/apb_pkg.sv
// Shared types and default widths for the command-to-APB bridge.
package apb_pkg;

   localparam int APB_ADDR_W  = 32;
   localparam int APB_DATA_W  = 32;
   localparam int APB_PROT_W  = 3;
   localparam int APB_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_state_t;

   // Response as seen on the rsp_* port at the default data width.
   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_wait_cnt.sv
// ACCESS-phase wait-state counter. Cleared on entry to ACCESS, counts each
// ACCESS cycle without pready, flags the last cycle allowed before timeout.
module apb_wait_cnt #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic prst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   // Counter saturates at LAST so it can never wrap if the FSM lingers.
   always_ff @(posedge clk) begin
      if (prst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != LAST)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = (cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// Command-to-APB bridge: one transfer outstanding, registered APB request,
// wait-state timeout, registered valid/ready response.
//
//   state  | meaning
//   IDLE   | cmd_ready=1, waiting for a command
//   SETUP  | psel=1, penable=0 for exactly one cycle
//   ACCESS | psel=penable=1, waiting for pready or timeout
//   RESP   | rsp_valid=1, holding response until rsp_ready
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = APB_ADDR_W,
   parameter int DATA_WIDTH = APB_DATA_W,
   parameter int DATA_STRB  = DATA_WIDTH / 8,
   parameter int TIMEOUT    = APB_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  prst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_write,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [DATA_STRB-1:0]  cmd_strb,
   input  logic [APB_PROT_W-1:0] cmd_prot,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [APB_PROT_W-1:0] prot,
   output logic                  pwrite,
   output logic                  psel,
   output logic                  penable,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_STRB-1:0]  pstrb,
   input  logic                  pready,
   input  logic                  slverr,
   input  logic [DATA_WIDTH-1:0] prdata
);

   apb_state_t state;
   logic       cnt_clr;
   logic       cnt_en;
   logic       cnt_expire;

   // Counter restarts during SETUP so ACCESS always begins at zero.
   assign cnt_clr = (state == SETUP);
   assign cnt_en  = (state == ACCESS);

   apb_wait_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_cnt (
      .clk    (clk),
      .prst   (prst),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .expire (cnt_expire)
   );

   // Transfer sequencer with all bus and response outputs registered.
   always_ff @(posedge clk) begin
      if (prst) begin
         state       <= IDLE;
         cmd_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         paddr       <= '0;
         prot        <= '0;
         pwrite      <= 1'b0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwdata      <= '0;
         pstrb       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  paddr     <= cmd_addr;
                  pwrite    <= cmd_write;
                  pwdata    <= cmd_wdata;
                  prot      <= cmd_prot;
                  // Reads never carry strobes onto the bus.
                  pstrb     <= cmd_write ? cmd_strb : '0;
                  psel      <= 1'b1;
                  cmd_ready <= 1'b0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               // pready on the final allowed cycle still completes normally.
               if (pready) begin
                  rsp_rdata   <= pwrite ? '0 : prdata;
                  rsp_err     <= slverr;
                  rsp_timeout <= 1'b0;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else if (cnt_expire) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small APB register-slave model.
module tb_apb_master;
   import apb_pkg::*;

   logic        clk = 1'b0;
   logic        prst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic [2:0]  cmd_prot;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [31:0] paddr, pwdata, prdata;
   logic [2:0]  prot;
   logic        pwrite, psel, penable, pready, slverr;
   logic [3:0]  pstrb;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   apb_master dut (
      .clk         (clk),
      .prst        (prst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_write   (cmd_write),
      .cmd_wdata   (cmd_wdata),
      .cmd_strb    (cmd_strb),
      .cmd_prot    (cmd_prot),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .paddr       (paddr),
      .prot        (prot),
      .pwrite      (pwrite),
      .psel        (psel),
      .penable     (penable),
      .pwdata      (pwdata),
      .pstrb       (pstrb),
      .pready      (pready),
      .slverr      (slverr),
      .prdata      (prdata)
   );

   // Slave model: 16 word registers, configurable wait states, stuck or error.
   logic [31:0] mem [16];
   int wait_cfg   = 0;
   bit stuck      = 1'b0;
   bit err_cfg    = 1'b0;
   int acc_cycles = 0;

   assign pready = psel && penable && !stuck && (acc_cycles >= wait_cfg);
   assign slverr = err_cfg;
   assign prdata = mem[paddr[5:2]];

   always @(posedge clk) begin
      if (psel && penable) acc_cycles <= acc_cycles + 1;
      else                 acc_cycles <= 0;
      if (psel && penable && pready && pwrite)
         for (int b = 0; b < 4; b++)
            if (pstrb[b]) mem[paddr[5:2]][8*b +: 8] <= pwdata[8*b +: 8];
   end

   // Present one command at a negedge and hold it until accepted.
   task automatic send_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
      int n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      if (!cmd_ready) begin
         total++; bad++;
         $display("FAIL send_cmd: cmd_ready stayed %0b, want 1", cmd_ready);
      end
      cmd_addr = a; cmd_write = w; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 60) begin @(negedge clk); lat++; end
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      prst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready: got %0b want 1", cmd_ready); end
      total++;
      if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
         bad++;
         $display("FAIL rst_ctrl: psel/pen/pwr/rv/err/tmo=%b want 000000",
                  {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout});
      end
      total++;
      if ({paddr, pwdata, pstrb, prot, rsp_rdata} !== '0) begin
         bad++;
         $display("FAIL rst_data: paddr=%h pwdata=%h pstrb=%h prot=%h rdata=%h want all 0",
                  paddr, pwdata, pstrb, prot, rsp_rdata);
      end
      prst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write();
      send_cmd(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b010);
      total++;
      if ({psel, penable, cmd_ready} !== 3'b100) begin
         bad++; $display("FAIL wr_setup_ctrl: psel/pen/cmd_ready=%b want 100", {psel, penable, cmd_ready});
      end
      total++;
      if (paddr !== 32'h10 || pwdata !== 32'hDEADBEEF || pstrb !== 4'hF || pwrite !== 1'b1 || prot !== 3'b010) begin
         bad++;
         $display("FAIL wr_setup_bus: paddr=%h pwdata=%h pstrb=%h pwrite=%b prot=%b want 10 DEADBEEF F 1 010",
                  paddr, pwdata, pstrb, pwrite, prot);
      end
      @(negedge clk);
      total++;
      if ({psel, penable, rsp_valid} !== 3'b110 || pwdata !== 32'hDEADBEEF || paddr !== 32'h10) begin
         bad++;
         $display("FAIL wr_access: psel/pen/rv=%b pwdata=%h paddr=%h want 110 DEADBEEF 10",
                  {psel, penable, rsp_valid}, pwdata, paddr);
      end
      @(negedge clk);
      total++;
      if ({rsp_valid, psel, penable, rsp_err, rsp_timeout} !== 5'b10000 || rsp_rdata !== 32'h0) begin
         bad++;
         $display("FAIL wr_rsp: rv/psel/pen/err/tmo=%b rdata=%h want 10000 0",
                  {rsp_valid, psel, penable, rsp_err, rsp_timeout}, rsp_rdata);
      end
      take_rsp();
      total++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         bad++; $display("FAIL wr_done: rv/cmd_ready=%b want 01", {rsp_valid, cmd_ready});
      end
   endtask

   task automatic test_read();
      int lat;
      apb_rsp_t exp;
      exp = '{rdata: 32'hDEADBEEF, err: 1'b0, timeout: 1'b0};
      send_cmd(32'h10, 1'b0, 32'h12345678, 4'hF, 3'b000);
      total++;
      if (pstrb !== 4'h0 || pwrite !== 1'b0 || psel !== 1'b1) begin
         bad++; $display("FAIL rd_setup: pstrb=%h pwrite=%b psel=%b want 0 0 1", pstrb, pwrite, psel);
      end
      wait_rsp(lat);
      // rsp_valid rises on the second edge after the accepting edge.
      total++;
      if (rsp_valid !== 1'b1 || lat != 2) begin
         bad++; $display("FAIL rd_latency: rv=%b edges=%0d want 1 2", rsp_valid, lat);
      end
      total++;
      if ({rsp_rdata, rsp_err, rsp_timeout} !== exp) begin
         bad++; $display("FAIL rd_data: rdata=%h err=%b tmo=%b want DEADBEEF 0 0", rsp_rdata, rsp_err, rsp_timeout);
      end
      take_rsp();
   endtask

   task automatic test_wait_states();
      int  pen = 0;
      int  n   = 0;
      bit  moved = 0;
      wait_cfg = 5;
      send_cmd(32'h24, 1'b1, 32'hA5A50001, 4'hF, 3'b000);
      while (!rsp_valid && n < 40) begin
         if (psel && penable) begin
            pen++;
            if (paddr !== 32'h24 || pwdata !== 32'hA5A50001) moved = 1;
         end
         @(negedge clk); n++;
      end
      total++;
      if (pen != 6 || moved) begin
         bad++; $display("FAIL ws_access: penable cycles=%0d moved=%0b want 6 0", pen, moved);
      end
      total++;
      if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin
         bad++; $display("FAIL ws_rsp: rv/err/tmo=%b want 100", {rsp_valid, rsp_err, rsp_timeout});
      end
      take_rsp();
      wait_cfg = 0;
   endtask

   task automatic test_timeout();
      int pen = 0;
      int n   = 0;
      stuck = 1'b1;
      send_cmd(32'h28, 1'b0, 32'h0, 4'h0, 3'b000);
      while (!rsp_valid && n < 60) begin
         if (psel && penable) pen++;
         @(negedge clk); n++;
      end
      total++;
      if (pen != 16) begin bad++; $display("FAIL to_cycles: access cycles=%0d want 16", pen); end
      total++;
      if ({rsp_valid, rsp_err, rsp_timeout, psel, penable} !== 5'b11100 || rsp_rdata !== 32'h0) begin
         bad++;
         $display("FAIL to_rsp: rv/err/tmo/psel/pen=%b rdata=%h want 11100 0",
                  {rsp_valid, rsp_err, rsp_timeout, psel, penable}, rsp_rdata);
      end
      take_rsp();
      stuck = 1'b0;
   endtask

   task automatic test_slverr_hold();
      int lat;
      err_cfg = 1'b1;
      send_cmd(32'h2C, 1'b1, 32'h11, 4'hF, 3'b000);
      wait_rsp(lat);
      err_cfg = 1'b0;
      total++;
      if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin
         bad++; $display("FAIL se_rsp: rv/err/tmo=%b want 110", {rsp_valid, rsp_err, rsp_timeout});
      end
      cmd_addr = 32'h30; cmd_write = 1'b1; cmd_wdata = 32'h22; cmd_strb = 4'hF;
      cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if ({rsp_valid, rsp_err, cmd_ready, psel} !== 4'b1100) begin
            bad++;
            $display("FAIL se_hold[%0d]: rv/err/cmd_ready/psel=%b want 1100", i,
                     {rsp_valid, rsp_err, cmd_ready, psel});
         end
      end
      cmd_valid = 1'b0;
      take_rsp();
      total++;
      if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
         bad++; $display("FAIL se_release: cmd_ready/psel/rv=%b want 100", {cmd_ready, psel, rsp_valid});
      end
   endtask

   task automatic test_reset_mid();
      stuck = 1'b1;
      send_cmd(32'h34, 1'b0, 32'h0, 4'h0, 3'b101);
      @(negedge clk);
      total++;
      if ({psel, penable} !== 2'b11) begin
         bad++; $display("FAIL rm_pre: psel/pen=%b want 11", {psel, penable});
      end
      prst = 1'b1;
      @(negedge clk);
      total++;
      if ({psel, penable, cmd_ready, rsp_valid} !== 4'b0010 || paddr !== 32'h0) begin
         bad++;
         $display("FAIL rm_after: psel/pen/cmd_ready/rv=%b paddr=%h want 0010 0",
                  {psel, penable, cmd_ready, rsp_valid}, paddr);
      end
      stuck = 1'b0;
      @(negedge clk);
      prst = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({rsp_valid, psel} !== 2'b00) begin
         bad++; $display("FAIL rm_quiet: rv/psel=%b want 00", {rsp_valid, psel});
      end
   endtask

   task automatic test_sweep();
      int lat;
      logic [31:0] d;
      logic [31:0] a;
      for (int i = 0; i < 16; i++) begin
         d = 32'hC0DE0000 | (i << 8) | i;
         a = i * 4;
         send_cmd(a, 1'b1, d, 4'hF, 3'b000);
         wait_rsp(lat);
         total++;
         if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
            bad++; $display("FAIL sw_wr[%0d]: rv=%b err=%b want 1 0", i, rsp_valid, rsp_err);
         end
         take_rsp();
      end
      // Partial strobe on word 2: bytes 0 and 2 replaced.
      send_cmd(32'h8, 1'b1, 32'hFFFFFFFF, 4'b0101, 3'b000);
      wait_rsp(lat);
      take_rsp();
      for (int i = 0; i < 16; i++) begin
         d = 32'hC0DE0000 | (i << 8) | i;
         if (i == 2) d = 32'hC0FF02FF;
         a = i * 4;
         send_cmd(a, 1'b0, 32'h0, 4'h0, 3'b000);
         wait_rsp(lat);
         total++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== d || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL sw_rd[%0d]: rv=%b rdata=%h err=%b want 1 %h 0", i, rsp_valid, rsp_rdata, rsp_err, d);
         end
         take_rsp();
      end
   endtask

   task automatic test_back_to_back();
      int starts[$];
      int n = 0;
      cmd_addr = 32'h3C; cmd_write = 1'b1; cmd_wdata = 32'h5A5A5A5A; cmd_strb = 4'hF; cmd_prot = 3'b000;
      cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (psel && !penable) starts.push_back(cyc);
      end
      cmd_valid = 1'b0;
      while (!(cmd_ready && !rsp_valid) && n < 20) begin @(negedge clk); n++; end
      rsp_ready = 1'b0;
      total++;
      if (starts.size() < 3) begin
         bad++; $display("FAIL b2b_count: transfers=%0d want >=3", starts.size());
      end
      for (int i = 1; i < starts.size(); i++) begin
         total++;
         if (starts[i] - starts[i-1] != 4) begin
            bad++; $display("FAIL b2b_gap[%0d]: cycles=%0d want 4", i, starts[i] - starts[i-1]);
         end
      end
   endtask

   initial begin
      prst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_wait_states();
      test_timeout();
      test_slverr_hold();
      test_reset_mid();
      test_sweep();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
